// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/ack port, decode-side valid/ready
// handshake with next-PC selection, and fetch status outputs.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            instr_ready;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;

    logic [31:0]     fetch_count;
    logic            fetch_fault;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, pc, pc_plus4,
        input  instr_ready, pc_src, pc_target,
        output fetch_count, fetch_fault
    );

    // Memory and decode side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, pc, pc_plus4,
        output instr_ready, pc_src, pc_target,
        input  fetch_count, fetch_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: holds the PC, fetches one word per instruction over req/ack.
// Define IFETCH_MISALIGN_TRAP_EN to halt on a misaligned next PC instead of aligning it.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input logic                 clk,
    input logic                 reset_n,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     count_q, count_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign next_pc  = bus.pc_src ? bus.pc_target : pc_plus4;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked block and wins over
    // every other input at that edge; only registers, no memories, need a reset value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            count_q <= '0;
            req_q   <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            req_q   <= req_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        fault_d = fault_q;
`endif

        unique case (state_q)
            S_REQ: begin
                // Gating on req_q drops a stale ack landing in the first cycle after reset.
                if (req_q && bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.instr_ready) begin
                    count_d = count_q + 32'd1;
                    instr_d = NOP_INSTR;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    pc_d = next_pc;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    pc_d    = next_pc & ~XLEN'(3);
                    state_d = S_REQ;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Registered request: high in every cycle the FSM spends in REQ.
        req_d = (state_d == S_REQ);
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == S_VALID);
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_count = count_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus a randomized
// fetch/accept stretch, all compared against a transaction-level PC/count model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural PC, accepted count, current instruction, fault state.
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_instr;
    logic        m_fault;
    logic        m_halt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic src, input logic [31:0] tgt);
        logic [31:0] n;
        n = src ? tgt : m_pc + 32'd4;
`ifndef IFETCH_MISALIGN_TRAP_EN
        n = n - (n % 32'd4);
`endif
        return n;
    endfunction

    task automatic wait_req(output int waited);
        waited = 0;
        while (bus.imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", {31'd0, bus.imem_req}, 32'd1);
    endtask

    // Serve one request after lat idle cycles; instr_ready pulses during REQ must be ignored.
    task automatic fetch(input int lat, input logic [31:0] data, output int waited);
        wait_req(waited);
        check("imem_addr", bus.imem_addr, m_pc);
        for (int i = 0; i < lat; i++) begin
            bus.instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("req_held", {31'd0, bus.imem_req}, 32'd1);
            check("valid_while_req", {31'd0, bus.instr_valid}, 32'd0);
        end
        bus.instr_ready = 1'b0;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = data;
        check("valid_before_ack", {31'd0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        m_instr = data;
        check("valid_after_ack", {31'd0, bus.instr_valid}, 32'd1);
        check("instr", bus.instr, data);
        check("pc", bus.pc, m_pc);
        check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        check("req_dropped", {31'd0, bus.imem_req}, 32'd0);
        check("count_hold", bus.fetch_count, m_count);
    endtask

    // Hold VALID for stall cycles (with stray acks), then accept with the given next-PC choice.
    task automatic accept(input logic src, input logic [31:0] tgt, input int stall);
        for (int i = 0; i < stall; i++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = $urandom;
            @(negedge clk);
            check("valid_stall", {31'd0, bus.instr_valid}, 32'd1);
            check("instr_stall", bus.instr, m_instr);
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.pc_src      = src;
        bus.pc_target   = tgt;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.pc_src      = 1'($urandom_range(0, 1));
        bus.pc_target   = $urandom;
        m_pc    = model_next(src, tgt);
        m_count = m_count + 32'd1;
        m_instr = NOP_INSTR;
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (m_pc % 32'd4 != 0) begin
            m_halt  = 1'b1;
            m_fault = 1'b1;
        end
`endif
        check("count_acc", bus.fetch_count, m_count);
        check("pc_acc", bus.pc, m_pc);
        check("instr_nop", bus.instr, NOP_INSTR);
        check("valid_acc", {31'd0, bus.instr_valid}, 32'd0);
        check("fault_acc", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
        check("req_acc", {31'd0, bus.imem_req}, {31'd0, !m_halt});
        if (!m_halt) check("addr_acc", bus.imem_addr, m_pc);
    endtask

    task automatic reset_model();
        m_pc    = RESET_PC;
        m_count = 32'd0;
        m_instr = NOP_INSTR;
        m_fault = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        check({tag, "_instr"}, bus.instr, NOP_INSTR);
        check({tag, "_pc"}, bus.pc, RESET_PC);
        check({tag, "_count"}, bus.fetch_count, 32'd0);
        check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
        check({tag, "_fault"}, {31'd0, bus.fetch_fault}, 32'd0);
    endtask

    initial begin
        int waited;
        logic src;
        logic [31:0] tgt;

        reset_n         = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.instr_ready = 1'b0;
        bus.pc_src      = 1'b0;
        bus.pc_target   = 32'd0;
        reset_model();

        // Reset then release; first fetch acked after 3 cycles.
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("req_after_release", {31'd0, bus.imem_req}, 32'd1);
        fetch(3, 32'h0050_0113, waited);
        check("first_wait", waited, 32'd0);

        // Three sequential accepts with zero ack latency: back-to-back requests.
        for (int i = 0; i < 3; i++) begin
            accept(1'b0, 32'd0, 0);
            fetch(0, $urandom, waited);
            check("seq_wait", waited, 32'd0);
        end
        check("seq_count", bus.fetch_count, 32'd3);
        check("seq_pc", bus.pc, 32'h0000_000C);

        // Taken branch from pc=0x10 to 0x40.
        accept(1'b0, 32'd0, 1);
        fetch(1, $urandom, waited);
        check("br_src_pc", bus.pc, 32'h0000_0010);
        accept(1'b1, 32'h0000_0040, 0);
        fetch(0, $urandom, waited);
        check("br_dst_pc", bus.pc, 32'h0000_0040);

        // Randomized stretch with aligned targets.
        for (int i = 0; i < 24; i++) begin
            src = 1'($urandom_range(0, 1));
            tgt = $urandom & 32'hFFFF_FFFC;
            accept(src, tgt, $urandom_range(0, 2));
            fetch($urandom_range(0, 3), $urandom, waited);
        end

        // PC wrap from 0xFFFF_FFFC to 0.
        accept(1'b1, 32'hFFFF_FFFC, 0);
        fetch(2, $urandom, waited);
        check("wrap_pc_plus4", bus.pc_plus4, 32'd0);
        accept(1'b0, 32'd0, 0);
        check("wrap_pc", bus.pc, 32'd0);

        // Reset while requesting with an ack in the same cycle: ack must not be captured.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        reset_n        = 1'b0;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        reset_model();
        check_reset_state("rst_req");
        reset_n = 1'b1;
        fetch(1, 32'h0010_0093, waited);

        // Reset while an accept is presented: count still clears.
        accept(1'b0, 32'd0, 0);
        fetch(0, $urandom, waited);
        bus.instr_ready = 1'b1;
        reset_n         = 1'b0;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        reset_model();
        check_reset_state("rst_valid");
        reset_n = 1'b1;
        fetch(0, $urandom, waited);

        // Misaligned branch target 0x42.
        accept(1'b1, 32'h0000_0042, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("trap_pc", bus.pc, 32'h0000_0042);
        repeat (3) begin
            bus.imem_ack = 1'b1;
            @(negedge clk);
            check("halt_req", {31'd0, bus.imem_req}, 32'd0);
            check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
            check("halt_fault", {31'd0, bus.fetch_fault}, 32'd1);
        end
        bus.imem_ack = 1'b0;
`else
        check("align_addr", bus.imem_addr, 32'h0000_0040);
        fetch(0, $urandom, waited);
        check("align_fault", {31'd0, bus.fetch_fault}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
